mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage initiator for the data memory port of the pipelined MIPS core. Takes one load/store per instruction from the pipeline and converts byte/halfword/word accesses into word-aligned, byte-enabled requests on a valid/ack memory port. Aligns and sign- or zero-extends load data, stalls the pipeline while a request is outstanding, and flags bus errors on timeout.

## Interface
- MAX_WAIT, 16: cycles in ISSUE without mem_ack before a bus error (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted when 0)
- req_valid  in  1  MEM stage holds a load/store
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  hold MEM stage and upstream
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: bus error or misalignment
- rdata  out  32  load result, valid with done
- mem_req  out  1  request to memory
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  32  word address, [1:0] always 0
- mem_be  out  4  byte enables, bit i = bits [8i+7:8i]
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completes the request in the current cycle
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- FSM: IDLE, ISSUE, RESP.
- IDLE: on req_valid, latch mem_we, mem_addr = {req_addr[31:2],2'b00}, mem_be, mem_wdata, size, signed, and offset a = req_addr[1:0]. Go to ISSUE.
- ISSUE: mem_req = 1, request fields held stable. On mem_ack, capture rdata (loads) and go to RESP with err=0. If no ack by the MAX_WAIT-th ISSUE cycle, go to RESP with err=1 and rdata=0.
- RESP: done=1 for one cycle, then return to IDLE. req_valid is ignored in RESP because it is still the completing instruction.
- stall = (IDLE & req_valid) | ISSUE. It is 0 in RESP, so the pipeline advances on the RESP edge.
- Byte enables, little-endian:
  - byte: be = 1<<a
  - half: be = a[1] ? 1100 : 0011
  - word: be = 1111
- Store data lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged. Loads drive the same be.
- Load data: take the lane selected by a (byte) or a[1] (half), then extend to 32 bits per req_signed. Word loads pass through.
- mem_ack outside ISSUE is ignored.

## Timing
- Reset values: state IDLE, done 0, err 0, rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, timeout counter 0.
- stall during reset equals req_valid.
- Reset assertion mid-ISSUE drops mem_req asynchronously and abandons the access. No done pulse follows.
- Minimum latency, ack in the first ISSUE cycle:
  - cycle 0: accept
  - cycle 1: mem_req
  - cycle 2: done
  - The instruction occupies MEM for 3 cycles.
- Each extra wait cycle adds one cycle.
- Timeout counter clears on entering ISSUE and increments every ISSUE cycle without ack. Timeout fires when the counter is MAX_WAIT-1 and mem_ack=0.
- mem_ack together with the timeout condition: ack wins, err=0.
- Back-to-back accesses: a new request is accepted in the IDLE cycle after RESP. No idle bubble beyond RESP is required.

## Configuration
- MISALIGN_EXC_EN defined:
  - half with a[0]=1, or word with a≠0, issues no memory request.
  - IDLE goes directly to RESP with err=1, rdata=0, mem_req never asserted.
  - Latency is 2 cycles.
- MISALIGN_EXC_EN undefined:
  - misaligned low bits are ignored: half uses a[1] only, word uses neither.
  - The access proceeds normally with err=0.

## Test plan
- Store sw to 0x0000_1004 with wdata 0x1234_5678, ack in the first ISSUE cycle:
  - mem_addr 0x1004, be 1111, mem_wdata 0x1234_5678, mem_we=1
  - done in cycle 2, stall high in cycles 0–1 only
- Byte load lb at 0x...03, mem_rdata 0x80FF_FF7F:
  - be 1000, rdata 0xFFFF_FF80
- Same access as lbu: rdata 0x0000_0080.
- Half store sh at 0x...02 with wdata 0xAAAA_BEEF:
  - be 1100, mem_wdata 0xBEEF_BEEF
- Half load lh at 0x...02, mem_rdata 0x8001_0000:
  - rdata 0xFFFF_8001
- Timeout with MAX_WAIT=4, mem_ack held 0:
  - mem_req high exactly 4 cycles, then done=1, err=1, rdata=0
- Ack arriving on the 4th cycle gives err=0.
- Reset pulled low in the 2nd ISSUE cycle: mem_req falls immediately, no done pulse; after release, a new lw completes normally.
- Misaligned lw at 0x...02:
  - with MISALIGN_EXC_EN: no mem_req, done+err in cycle 1
  - without MISALIGN_EXC_EN: mem_addr 0x...00, be 1111, err=0

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response and memory-side valid/ack signals of mem_access_unit.
// The master modport is the unit itself; slave is the pipeline plus memory around it.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output stall, done, err, rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  stall, done, err, rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: word-aligned byte-enabled valid/ack requests with timeout.
// Define MISALIGN_EXC_EN to fault misaligned half/word accesses without touching memory.
module mem_access_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.master bus
);
    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_wdata;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [1:0]    r_off;

    logic [1:0]    w_off;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic          w_timeout;

    assign w_off = bus.req_addr[1:0];

    // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_EXC_EN
    logic w_misalign;
    assign w_misalign = ((bus.req_size == 2'b01) && w_off[0]) ||
                        (bus.req_size[1] && (w_off != 2'b00));
`endif

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            2'd3:    w_byte = bus.mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = bus.mem_rdata;
        endcase
    end

    assign w_timeout = (r_cnt == CW'(MAX_WAIT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_off       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_mem_we    <= bus.req_we;
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_off       <= w_off;
                        r_cnt       <= '0;
                        r_rdata     <= '0;
                        r_err       <= 1'b0;
`ifdef MISALIGN_EXC_EN
                        if (w_misalign) begin
                            r_state <= S_RESP;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
`else
                        r_state     <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    // Ack in the final allowed cycle still beats the timeout.
                    if (bus.mem_ack) begin
                        r_state <= S_RESP;
                        r_err   <= 1'b0;
                        r_rdata <= r_mem_we ? 32'd0 : w_load;
                    end else if (w_timeout) begin
                        r_state <= S_RESP;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req   = (r_state == S_ISSUE);
    assign bus.done      = (r_state == S_RESP);
    assign bus.stall     = ((r_state == S_IDLE) && bus.req_valid) || (r_state == S_ISSUE);
    assign bus.err       = r_err;
    assign bus.rdata     = r_rdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed load/store cases plus randomized accesses against
// a transaction-level model of alignment, extension, latency and timeout.
module tb_mem_access_unit;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mem_access_unit_if bus ();

    mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete access, entered and left at a falling edge. ack_cycle counts ISSUE
    // cycles from 1; 0 means memory never answers. req_valid stays high through RESP.
    task automatic do_access(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_cycle, input logic [31:0] rd);
        logic [1:0]  a;
        logic        fault;
        logic        timed_out;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic [31:0] lane;
        int          done_cyc;

        a      = addr[1:0];
        fault  = 1'b0;
`ifdef MISALIGN_EXC_EN
        fault  = ((size == 2'd1) && a[0]) || ((size >= 2'd2) && (a != 2'd0));
`endif
        timed_out = (ack_cycle == 0) || (ack_cycle > MAX_WAIT);
        done_cyc  = timed_out ? MAX_WAIT : ack_cycle;

        if (size == 2'd0) begin
            exp_be = 4'(1 << a);
            exp_wd = {4{wdata[7:0]}};
            lane   = (rd >> (8 * a)) & 32'hFF;
            exp_rd = (sgn && lane[7]) ? (lane | 32'hFFFF_FF00) : lane;
        end else if (size == 2'd1) begin
            exp_be = (a >= 2) ? 4'b1100 : 4'b0011;
            exp_wd = {2{wdata[15:0]}};
            lane   = (rd >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
            exp_rd = (sgn && lane[15]) ? (lane | 32'hFFFF_0000) : lane;
        end else begin
            exp_be = 4'hF;
            exp_wd = wdata;
            exp_rd = rd;
        end

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.mem_rdata  = $urandom;
        #1;
        check("accept_mem_req", 32'(bus.mem_req), 32'd0);
        check("accept_stall", 32'(bus.stall), 32'd1);
        check("accept_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.mem_ack = 1'b0;

        if (fault) begin
            check("fault_done", 32'(bus.done), 32'd1);
            check("fault_err", 32'(bus.err), 32'd1);
            check("fault_rdata", bus.rdata, 32'd0);
            check("fault_mem_req", 32'(bus.mem_req), 32'd0);
            check("fault_stall", 32'(bus.stall), 32'd0);
        end else begin
            for (int i = 1; i <= done_cyc; i++) begin
                check("issue_mem_req", 32'(bus.mem_req), 32'd1);
                check("issue_stall", 32'(bus.stall), 32'd1);
                check("issue_done", 32'(bus.done), 32'd0);
                if (i == 1) begin
                    check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                    check("mem_be", 32'(bus.mem_be), 32'(exp_be));
                    check("mem_we", 32'(bus.mem_we), 32'(we));
                    if (we) check("mem_wdata", bus.mem_wdata, exp_wd);
                end
                bus.mem_ack   = (i == ack_cycle);
                bus.mem_rdata = (i == ack_cycle) ? rd : $urandom;
                @(negedge clk);
                bus.mem_ack   = 1'b0;
            end
            check("resp_done", 32'(bus.done), 32'd1);
            check("resp_err", 32'(bus.err), 32'(timed_out));
            check("resp_mem_req", 32'(bus.mem_req), 32'd0);
            check("resp_stall", 32'(bus.stall), 32'd0);
            if (!we) check("resp_rdata", bus.rdata, timed_out ? 32'd0 : exp_rd);
        end

        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
    endtask

    task automatic idle_cycle();
        bus.req_valid = 1'b0;
        #1;
        check("idle_mem_req", 32'(bus.mem_req), 32'd0);
        check("idle_stall", 32'(bus.stall), 32'd0);
        check("idle_done", 32'(bus.done), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
        check({tag, "_rdata"}, bus.rdata, 32'd0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = '0;

        repeat (2) @(negedge clk);
        check_reset_values("rst");
        check("rst_stall_lo", 32'(bus.stall), 32'd0);
        bus.req_valid = 1'b1;
        #1;
        check("rst_stall_hi", 32'(bus.stall), 32'd1);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        do_access(1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'h1234_5678, 1, 32'h0);
        idle_cycle();
        do_access(1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0, 1, 32'h80FF_FF7F);
        do_access(1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0, 2, 32'h80FF_FF7F);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'hAAAA_BEEF, 1, 32'h0);
        do_access(1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0, 1, 32'h8001_0000);
        do_access(1'b0, 2'd1, 1'b0, 32'h0000_3000, 32'h0, 3, 32'h8001_F00D);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 0, 32'hDEAD_BEEF);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, MAX_WAIT, 32'hCAFE_F00D);
        do_access(1'b0, 2'd3, 1'b0, 32'h0000_4008, 32'h0, 1, 32'h1357_9BDF);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_5002, 32'h0, 1, 32'h0BAD_F00D);
        do_access(1'b1, 2'd1, 1'b0, 32'h0000_5001, 32'h0000_55AA, 1, 32'h0);
        idle_cycle();

        // Abandon a load in its second ISSUE cycle with an asynchronous reset.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'd2;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0000_6000;
        @(negedge clk);
        check("rstmid_issue1", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        check("rstmid_issue2", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_mem_req_drop", 32'(bus.mem_req), 32'd0);
        check("rstmid_stall_valid", 32'(bus.stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_values("rstmid");
        end
        bus.req_valid = 1'b0;
        #1;
        check("rstmid_stall_novalid", 32'(bus.stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", 32'(bus.done), 32'd0);
        do_access(1'b0, 2'd2, 1'b0, 32'h0000_7010, 32'h0, 1, 32'h2468_ACE0);

        for (int n = 0; n < 250; n++) begin
            logic [1:0] sz;
            int         ackc;
            sz   = 2'($urandom_range(0, 3));
            ackc = $urandom_range(0, MAX_WAIT + 2);
            do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                      $urandom, $urandom, ackc, $urandom);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
